// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder slice.
//   - state_t              : 2-bit FSM state type
//   - ST_IDLE/ST_ADD/ST_DONE: FSM state encodings
//   - cnt_width()          : width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADD  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Sized so the counter can reach WIDTH without wrapping.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   One-bit full adder built from two half adders.
//   Ports:
//     a, b      : input bits
//     carry_in  : carry into this bit
//     sum       : a xor b xor carry_in
//     carry_out : carry out of this bit
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a     (a),
      .b     (b),
      .sum   (s0),
      .carry (c0)
   );

   half_adder u_ha1 (
      .a     (s0),
      .b     (carry_in),
      .sum   (sum),
      .carry (c1)
   );

   // Both half-adder carries can never be high together, so OR suffices.
   assign carry_out = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//   One-bit half adder.
//   Ports:
//     a, b  : input bits
//     sum   : a xor b
//     carry : a and b
// ---------------------------------------------------------------------------
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: one full_adder is stepped over WIDTH cycles, LSB first,
//   to compute a + b + carry_in. Operands and result use valid/ready.
//   Parameters:
//     WIDTH     : operand / sum width in bits (>= 1)
//   Ports:
//     clk       : clock, rising edge
//     reset     : synchronous, active-high
//     in_valid  : operand set present on a, b, carry_in
//     in_ready  : block idle and able to accept operands
//     a, b      : addends, sampled on the input handshake
//     carry_in  : carry into bit 0, sampled on the input handshake
//     out_valid : sum / carry_out hold a finished result
//     out_ready : consumer accepts the result
//     sum       : registered (a + b + carry_in) mod 2^WIDTH
//     carry_out : registered carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int unsigned      CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

   state_t            state;
   state_t            state_nx;
   logic [WIDTH-1:0]  a_sr;
   logic [WIDTH-1:0]  b_sr;
   logic [WIDTH-1:0]  res_sr;
   logic [WIDTH-1:0]  res_shift;
   logic              carry_q;
   logic [CW-1:0]     cnt;
   logic              fa_sum;
   logic              fa_co;

   full_adder u_fa (
      .a         (a_sr[0]),
      .b         (b_sr[0]),
      .carry_in  (carry_q),
      .sum       (fa_sum),
      .carry_out (fa_co)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_shift = fa_sum;
      end else begin : g_res_wn
         assign res_shift = {fa_sum, res_sr[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (in_valid)         state_nx = ST_ADD;
         ST_ADD:  if (cnt == CNT_LAST)  state_nx = ST_DONE;
         ST_DONE: if (out_ready)        state_nx = ST_IDLE;
         default:                       state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sr    <= a;
                  b_sr    <= b;
                  carry_q <= carry_in;
                  cnt     <= '0;
               end
            end
            ST_ADD: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               res_sr  <= res_shift;
               carry_q <= fa_co;
               cnt     <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Handshake flags decode registered state only.
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign sum       = res_sr;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       carry_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       carry_out;

   logic       w1_in_valid;
   logic       w1_in_ready;
   logic       w1_a;
   logic       w1_b;
   logic       w1_carry_in;
   logic       w1_out_valid;
   logic       w1_out_ready;
   logic       w1_sum;
   logic       w1_carry_out;

   int errors = 0;
   int checks = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out)
   );

   serial_adder #(.WIDTH(1)) dut_w1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (w1_in_valid),
      .in_ready  (w1_in_ready),
      .a         (w1_a),
      .b         (w1_b),
      .carry_in  (w1_carry_in),
      .out_valid (w1_out_valid),
      .out_ready (w1_out_ready),
      .sum       (w1_sum),
      .carry_out (w1_carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic accept8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      a        = av;
      b        = bv;
      carry_in = cv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid8(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic cv, input logic [7:0] es, input logic ec);
      int lat;
      out_ready = 1'b1;
      accept8(av, bv, cv);
      chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
      wait_valid8(lat);
      chk({tag, "_latency"}, lat, 32'd8);
      chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
      chk({tag, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
      tick();
      chk({tag, "_released"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_valid_low"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int         lat;
      int         results;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic [8:0] rsum;
      logic       done;

      results      = 0;
      reset        = 1'b1;
      in_valid     = 1'b0;
      a            = '0;
      b            = '0;
      carry_in     = 1'b0;
      out_ready    = 1'b1;
      w1_in_valid  = 1'b0;
      w1_a         = 1'b0;
      w1_b         = 1'b0;
      w1_carry_in  = 1'b0;
      w1_out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum",       {24'd0, sum}, 32'd0);
      chk("rst_carry",     {31'd0, carry_out}, 32'd0);
      chk("w1_rst_in_ready",  {31'd0, w1_in_ready}, 32'd1);
      chk("w1_rst_out_valid", {31'd0, w1_out_valid}, 32'd0);

      // Basic additions
      op8("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
      op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      op8("add_cin",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
      op8("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // Backpressure: result must hold, new operands ignored
      out_ready = 1'b0;
      accept8(8'h12, 8'h34, 1'b1);
      wait_valid8(lat);
      chk("bp_latency", lat, 32'd8);
      chk("bp_sum0",    {24'd0, sum}, 32'h47);
      chk("bp_carry0",  {31'd0, carry_out}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         a        = 8'hE0 + 8'(i);
         b        = 8'h0F;
         carry_in = 1'b1;
         in_valid = (i % 2 == 0);
         tick();
         chk("bp_sum_hold",   {24'd0, sum}, 32'h47);
         chk("bp_carry_hold", {31'd0, carry_out}, 32'd0);
         chk("bp_in_ready",   {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid",  {31'd0, out_valid}, 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("bp_no_ghost_op", {31'd0, in_ready}, 32'd1);

      // Reset together with an input handshake: reset wins
      a        = 8'h77;
      b        = 8'h11;
      in_valid = 1'b1;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("rst_vs_hs_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("rst_vs_hs_out_valid", {31'd0, out_valid}, 32'd0);

      // Reset during the 4th ADD cycle discards the operation
      accept8(8'hAA, 8'h55, 1'b1);
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_sum",       {24'd0, sum}, 32'd0);
      chk("midrst_carry",     {31'd0, carry_out}, 32'd0);
      op8("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

      // WIDTH=1 instance: single ADD cycle
      w1_a        = 1'b1;
      w1_b        = 1'b1;
      w1_carry_in = 1'b1;
      w1_in_valid = 1'b1;
      tick();
      w1_in_valid = 1'b0;
      lat = 0;
      while (!w1_out_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk("w1_latency", lat, 32'd1);
      chk("w1_sum",     {31'd0, w1_sum}, 32'd1);
      chk("w1_carry",   {31'd0, w1_carry_out}, 32'd1);
      tick();
      chk("w1_released", {31'd0, w1_in_ready}, 32'd1);
      w1_a        = 1'b1;
      w1_b        = 1'b0;
      w1_carry_in = 1'b0;
      w1_in_valid = 1'b1;
      tick();
      w1_in_valid = 1'b0;
      tick();
      chk("w1b_out_valid", {31'd0, w1_out_valid}, 32'd1);
      chk("w1b_sum",       {31'd0, w1_sum}, 32'd1);
      chk("w1b_carry",     {31'd0, w1_carry_out}, 32'd0);

      // Random back-to-back operations with random output backpressure
      for (int n = 0; n < 1000; n++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rc   = 1'($urandom_range(0, 1));
         rsum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         out_ready = 1'($urandom_range(0, 1));
         accept8(ra, rb, rc);
         wait_valid8(lat);
         chk("rnd_latency", lat, 32'd8);
         done = 1'b0;
         for (int k = 0; k < 16 && !done; k++) begin
            chk("rnd_sum",   {24'd0, sum}, {24'd0, rsum[7:0]});
            chk("rnd_carry", {31'd0, carry_out}, {31'd0, rsum[8]});
            out_ready = (k == 15) ? 1'b1 : 1'($urandom_range(0, 1));
            done      = out_ready & out_valid;
            tick();
         end
         if (done) results++;
         chk("rnd_released", {31'd0, in_ready}, 32'd1);
      end
      chk("rnd_result_count", results, 32'd1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
